// File: rtl/dma_bus_master_pkg.sv
// Shared encodings and field widths for the DMA single-word bus master.
package dma_pkg;

    localparam int ADDR_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;

    // Burst-size code for a single-beat transfer.
    localparam logic [BURST_W-1:0] BURST_SIZE_ONE_DEFAULT = 8'd0;

    // Bus master sequencing states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_BEGIN  = 3'd2,
        S_RDWAIT = 3'd3,
        S_WRDATA = 3'd4,
        S_WREND  = 3'd5,
        S_ABORT  = 3'd6,
        S_DONE   = 3'd7
    } dma_state_e;

endpackage

// File: rtl/dma_bus_master_if.sv
// Front-end command handshake and shared system bus signals of the DMA master.
// Handshake: the front end issues a one-cycle s_readReady/s_dataReady strobe,
// which is only taken while s_busy is low; completion is a one-cycle
// s_endTransaction pulse qualified by s_dataValid/s_error. On the bus side the
// master holds requestTransaction until done, beginTransactionOut marks the
// single begin cycle, and dataValidOut is held while the slave asserts busyIn.
interface dma_bus_master_if;
    import dma_pkg::*;

    // Front-end side
    logic                s_readReady;
    logic                s_dataReady;
    logic [BE_W-1:0]     s_byteEnable;
    logic [ADDR_W-1:0]   s_address;
    logic [ADDR_W-1:0]   s_writeData;
    logic                s_busy;
    logic                s_endTransaction;
    logic                s_dataValid;
    logic [ADDR_W-1:0]   s_readData;
    logic                s_error;

    // System bus side
    logic                requestTransaction;
    logic                transactionGranted;
    logic                beginTransactionOut;
    logic [ADDR_W-1:0]   addressDataOut;
    logic [BE_W-1:0]     byteEnablesOut;
    logic                readNotWriteOut;
    logic [BURST_W-1:0]  burstSizeOut;
    logic                dataValidOut;
    logic                endTransactionOut;
    logic                busyIn;
    logic [ADDR_W-1:0]   addressDataIn;
    logic                dataValidIn;
    logic                endTransactionIn;
    logic                busErrorIn;

    // View of the DMA master itself.
    modport master (
        input  s_readReady, s_dataReady, s_byteEnable, s_address, s_writeData,
        output s_busy, s_endTransaction, s_dataValid, s_readData, s_error,
        output requestTransaction, beginTransactionOut, addressDataOut,
               byteEnablesOut, readNotWriteOut, burstSizeOut, dataValidOut,
               endTransactionOut,
        input  transactionGranted, busyIn, addressDataIn, dataValidIn,
               endTransactionIn, busErrorIn
    );

    // View of the environment: front end, arbiter and slave combined.
    modport slave (
        output s_readReady, s_dataReady, s_byteEnable, s_address, s_writeData,
        input  s_busy, s_endTransaction, s_dataValid, s_readData, s_error,
        input  requestTransaction, beginTransactionOut, addressDataOut,
               byteEnablesOut, readNotWriteOut, burstSizeOut, dataValidOut,
               endTransactionOut,
        output transactionGranted, busyIn, addressDataIn, dataValidIn,
               endTransactionIn, busErrorIn
    );

endinterface

// File: rtl/dma_bus_master_timeout_counter.sv
// Watchdog counter: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT_CYCLES-th waiting cycle is reached.
module dma_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // Expiry is flagged during the last allowed waiting cycle so the FSM
    // leaves after exactly TIMEOUT_CYCLES cycles of waiting.
    assign expired = enable && (count == LAST_COUNT);

    // Cycle counter; holds at the limit, cleared on reset or explicit clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/dma_bus_master.sv
// Single-word DMA bus master: takes one read/write command from the custom
// instruction front end, arbitrates for the system bus, runs one single-beat
// transaction and reports completion, with a watchdog against silent slaves.
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int                 TIMEOUT_CYCLES = 255,
    parameter logic [BURST_W-1:0] BURST_SIZE_ONE = BURST_SIZE_ONE_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    dma_bus_master_if.master  bus,
    output dma_state_e        state_dbg
);

    dma_state_e state, state_n;

    logic [ADDR_W-1:0] cmd_addr;
    logic [BE_W-1:0]   cmd_be;
    logic [ADDR_W-1:0] cmd_data;
    logic              cmd_rnw;
    logic [ADDR_W-1:0] rd_data;
    logic              got_data;
    logic              err_flag;

    logic accept;
    logic accept_rnw;
    logic capture;
    logic set_err;
    logic tmo_clear;
    logic tmo_en;
    logic tmo_expired;

    assign state_dbg = state;

    dma_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // State register; reset abandons any transaction without end pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Command latch, read data capture and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_addr <= '0;
            cmd_be   <= '0;
            cmd_data <= '0;
            cmd_rnw  <= 1'b0;
            rd_data  <= '0;
            got_data <= 1'b0;
            err_flag <= 1'b0;
        end else if (accept) begin
            cmd_addr <= bus.s_address;
            cmd_be   <= bus.s_byteEnable;
            cmd_data <= bus.s_writeData;
            cmd_rnw  <= accept_rnw;
            rd_data  <= '0;
            got_data <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (capture) begin
                rd_data  <= bus.addressDataIn;
                got_data <= 1'b1;
            end
            if (set_err) begin
                err_flag <= 1'b1;
            end
        end
    end

    // Next-state logic and Moore outputs for both bus and front end.
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        accept_rnw = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        tmo_clear  = 1'b0;
        tmo_en     = 1'b0;

        bus.s_busy              = 1'b1;
        bus.s_endTransaction    = 1'b0;
        bus.s_dataValid         = 1'b0;
        bus.s_readData          = '0;
        bus.s_error             = 1'b0;
        bus.requestTransaction  = 1'b0;
        bus.beginTransactionOut = 1'b0;
        bus.addressDataOut      = '0;
        bus.byteEnablesOut      = '0;
        bus.readNotWriteOut     = 1'b0;
        bus.burstSizeOut        = '0;
        bus.dataValidOut        = 1'b0;
        bus.endTransactionOut   = 1'b0;

        unique case (state)
            S_IDLE: begin
                bus.s_busy = 1'b0;
                // A read wins when both strobes arrive together.
                if (bus.s_readReady || bus.s_dataReady) begin
                    accept     = 1'b1;
                    accept_rnw = bus.s_readReady;
                    state_n    = S_REQ;
                end
            end
            S_REQ: begin
                bus.requestTransaction = 1'b1;
                if (bus.transactionGranted) begin
                    state_n = S_BEGIN;
                end
            end
            S_BEGIN: begin
                bus.requestTransaction  = 1'b1;
                bus.beginTransactionOut = 1'b1;
                bus.addressDataOut      = cmd_addr;
                bus.byteEnablesOut      = cmd_be;
                bus.readNotWriteOut     = cmd_rnw;
                bus.burstSizeOut        = BURST_SIZE_ONE;
                tmo_clear               = 1'b1;
                state_n                 = cmd_rnw ? S_RDWAIT : S_WRDATA;
            end
            S_RDWAIT: begin
                bus.requestTransaction = 1'b1;
                tmo_en                 = 1'b1;
                capture                = bus.dataValidIn;
                // Slave responses take precedence over the watchdog.
                if (bus.busErrorIn) begin
                    set_err = 1'b1;
                    state_n = S_DONE;
                end else if (bus.endTransactionIn) begin
                    set_err = !(bus.dataValidIn || got_data);
                    state_n = S_DONE;
                end else if (tmo_expired) begin
                    state_n = S_ABORT;
                end
            end
            S_WRDATA: begin
                bus.requestTransaction = 1'b1;
                bus.dataValidOut       = 1'b1;
                bus.addressDataOut     = cmd_data;
                tmo_en                 = 1'b1;
                if (bus.busErrorIn) begin
                    set_err = 1'b1;
                    state_n = S_DONE;
                end else if (!bus.busyIn) begin
                    state_n = S_WREND;
                end else if (tmo_expired) begin
                    state_n = S_ABORT;
                end
            end
            S_WREND: begin
                bus.requestTransaction = 1'b1;
                bus.endTransactionOut  = 1'b1;
                state_n                = S_DONE;
            end
            S_ABORT: begin
                bus.requestTransaction = 1'b1;
                bus.endTransactionOut  = 1'b1;
                set_err                = 1'b1;
                state_n                = S_DONE;
            end
            S_DONE: begin
                bus.s_endTransaction = 1'b1;
                bus.s_error          = err_flag;
                if (cmd_rnw && !err_flag) begin
                    bus.s_dataValid = 1'b1;
                    bus.s_readData  = rd_data;
                end
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master: reads, writes, grant delay, slave stall,
// watchdog abort, bus error, strobe priority/ignoring, and mid-transfer reset.
module tb_dma_bus_master;
    import dma_pkg::*;

    logic       clock;
    logic       reset;
    dma_state_e state_dbg;
    int         checks;
    int         passes;
    int         fails;
    int         end_cnt;

    dma_bus_master_if bus();

    dma_bus_master #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input dma_state_e exp);
        check(tag, 32'(state_dbg), 32'(exp));
    endtask

    task automatic clear_inputs();
        bus.s_readReady        = 1'b0;
        bus.s_dataReady        = 1'b0;
        bus.s_byteEnable       = '0;
        bus.s_address          = '0;
        bus.s_writeData        = '0;
        bus.transactionGranted = 1'b0;
        bus.busyIn             = 1'b0;
        bus.addressDataIn      = '0;
        bus.dataValidIn        = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.s_busy), 0);
        check({tag, "_send"}, 32'(bus.s_endTransaction), 0);
        check({tag, "_req"}, 32'(bus.requestTransaction), 0);
        check({tag, "_addr"}, bus.addressDataOut, 0);
        check({tag, "_dvout"}, 32'(bus.dataValidOut), 0);
        check({tag, "_endout"}, 32'(bus.endTransactionOut), 0);
        check({tag, "_begin"}, 32'(bus.beginTransactionOut), 0);
        check_state({tag, "_state"}, S_IDLE);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        reset  = 1'b1;
        clear_inputs();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: zero-wait read, immediate grant, data+end right after BEGIN.
        bus.s_readReady        = 1'b1;
        bus.s_address          = 32'h0000_0100;
        bus.s_byteEnable       = 4'b1111;
        bus.transactionGranted = 1'b1;
        tick();                                   // cycle 1: REQ
        bus.s_readReady = 1'b0;
        check_state("rd_req_state", S_REQ);
        check("rd_req", 32'(bus.requestTransaction), 1);
        check("rd_busy", 32'(bus.s_busy), 1);
        tick();                                   // cycle 2: BEGIN
        bus.transactionGranted = 1'b0;
        check("rd_begin", 32'(bus.beginTransactionOut), 1);
        check("rd_begin_addr", bus.addressDataOut, 32'h0000_0100);
        check("rd_begin_be", 32'(bus.byteEnablesOut), 32'hF);
        check("rd_begin_rnw", 32'(bus.readNotWriteOut), 1);
        check("rd_begin_burst", 32'(bus.burstSizeOut), 0);
        tick();                                   // cycle 3: RDWAIT
        check_state("rd_wait_state", S_RDWAIT);
        check("rd_wait_begin", 32'(bus.beginTransactionOut), 0);
        bus.dataValidIn      = 1'b1;
        bus.endTransactionIn = 1'b1;
        bus.addressDataIn    = 32'hDEAD_BEEF;
        tick();                                   // cycle 4: DONE
        clear_inputs();
        check("rd_send", 32'(bus.s_endTransaction), 1);
        check("rd_sdv", 32'(bus.s_dataValid), 1);
        check("rd_data", bus.s_readData, 32'hDEAD_BEEF);
        check("rd_err", 32'(bus.s_error), 0);
        check("rd_done_req", 32'(bus.requestTransaction), 0);
        tick();
        check("rd_idle_send", 32'(bus.s_endTransaction), 0);
        check("rd_idle_busy", 32'(bus.s_busy), 0);

        // 2: write, grant delayed 3 cycles, slave stalls 2 data cycles.
        bus.s_dataReady  = 1'b1;
        bus.s_address    = 32'h0000_0200;
        bus.s_byteEnable = 4'b0011;
        bus.s_writeData  = 32'hCAFE_F00D;
        tick();
        bus.s_dataReady = 1'b0;
        check_state("wr_req1", S_REQ);
        tick();
        check_state("wr_req2", S_REQ);
        tick();
        check_state("wr_req3", S_REQ);
        check("wr_req3_req", 32'(bus.requestTransaction), 1);
        bus.transactionGranted = 1'b1;
        tick();
        bus.transactionGranted = 1'b0;
        bus.busyIn             = 1'b1;
        check("wr_begin", 32'(bus.beginTransactionOut), 1);
        check("wr_begin_addr", bus.addressDataOut, 32'h0000_0200);
        check("wr_begin_be", 32'(bus.byteEnablesOut), 32'h3);
        check("wr_begin_rnw", 32'(bus.readNotWriteOut), 0);
        tick();
        check("wr_d1_dv", 32'(bus.dataValidOut), 1);
        check("wr_d1_data", bus.addressDataOut, 32'hCAFE_F00D);
        check("wr_d1_be", 32'(bus.byteEnablesOut), 0);
        tick();
        check("wr_d2_dv", 32'(bus.dataValidOut), 1);
        check("wr_d2_data", bus.addressDataOut, 32'hCAFE_F00D);
        tick();
        bus.busyIn = 1'b0;
        check("wr_d3_dv", 32'(bus.dataValidOut), 1);
        check("wr_d3_data", bus.addressDataOut, 32'hCAFE_F00D);
        check("wr_d3_endout", 32'(bus.endTransactionOut), 0);
        tick();
        check("wr_end_endout", 32'(bus.endTransactionOut), 1);
        check("wr_end_dv", 32'(bus.dataValidOut), 0);
        check("wr_end_req", 32'(bus.requestTransaction), 1);
        tick();
        clear_inputs();
        check("wr_done_endout", 32'(bus.endTransactionOut), 0);
        check("wr_send", 32'(bus.s_endTransaction), 1);
        check("wr_sdv", 32'(bus.s_dataValid), 0);
        check("wr_err", 32'(bus.s_error), 0);
        check("wr_rdata", bus.s_readData, 0);
        tick();

        // 3: read with a silent slave; watchdog of 4 cycles aborts.
        bus.s_readReady        = 1'b1;
        bus.s_address          = 32'h0000_0400;
        bus.transactionGranted = 1'b1;
        tick();
        bus.s_readReady = 1'b0;
        tick();                                   // BEGIN
        bus.transactionGranted = 1'b0;
        tick();
        check_state("to_wait1", S_RDWAIT);
        tick();
        check_state("to_wait2", S_RDWAIT);
        tick();
        check_state("to_wait3", S_RDWAIT);
        tick();
        check_state("to_wait4", S_RDWAIT);
        check("to_wait4_endout", 32'(bus.endTransactionOut), 0);
        tick();
        check_state("to_abort", S_ABORT);
        check("to_abort_endout", 32'(bus.endTransactionOut), 1);
        check("to_abort_req", 32'(bus.requestTransaction), 1);
        tick();
        check("to_send", 32'(bus.s_endTransaction), 1);
        check("to_err", 32'(bus.s_error), 1);
        check("to_sdv", 32'(bus.s_dataValid), 0);
        check("to_rdata", bus.s_readData, 0);
        check("to_done_endout", 32'(bus.endTransactionOut), 0);
        tick();

        // 4: read where the slave errors in the same cycle as its data.
        bus.s_readReady        = 1'b1;
        bus.s_address          = 32'h0000_0500;
        bus.transactionGranted = 1'b1;
        tick();
        bus.s_readReady = 1'b0;
        tick();
        bus.transactionGranted = 1'b0;
        tick();
        bus.dataValidIn   = 1'b1;
        bus.busErrorIn    = 1'b1;
        bus.addressDataIn = 32'h1234_5678;
        tick();
        clear_inputs();
        check("be_send", 32'(bus.s_endTransaction), 1);
        check("be_err", 32'(bus.s_error), 1);
        check("be_sdv", 32'(bus.s_dataValid), 0);
        check("be_rdata", bus.s_readData, 0);
        tick();

        // 5: simultaneous strobes pick the read; strobes while busy are ignored.
        bus.s_readReady        = 1'b1;
        bus.s_dataReady        = 1'b1;
        bus.s_address          = 32'h0000_0300;
        bus.s_writeData        = 32'h1111_2222;
        bus.transactionGranted = 1'b1;
        tick();
        bus.s_readReady = 1'b0;
        bus.s_dataReady = 1'b1;
        bus.s_address   = 32'h0000_0999;
        tick();                                   // BEGIN
        bus.s_dataReady        = 1'b0;
        bus.transactionGranted = 1'b0;
        check("pr_rnw", 32'(bus.readNotWriteOut), 1);
        check("pr_addr", bus.addressDataOut, 32'h0000_0300);
        tick();
        bus.s_readReady      = 1'b1;
        bus.dataValidIn      = 1'b1;
        bus.endTransactionIn = 1'b1;
        bus.addressDataIn    = 32'h0BAD_F00D;
        tick();
        clear_inputs();
        check("pr_sdv", 32'(bus.s_dataValid), 1);
        check("pr_data", bus.s_readData, 32'h0BAD_F00D);
        end_cnt = 32'(bus.s_endTransaction);
        for (int i = 0; i < 5; i++) begin
            tick();
            end_cnt += 32'(bus.s_endTransaction);
        end
        check("pr_end_count", end_cnt, 1);
        check_state("pr_final_state", S_IDLE);

        // 6: reset in the middle of a write data phase.
        bus.s_dataReady        = 1'b1;
        bus.s_address          = 32'h0000_0600;
        bus.s_writeData        = 32'hA5A5_A5A5;
        bus.transactionGranted = 1'b1;
        tick();
        bus.s_dataReady = 1'b0;
        tick();
        bus.transactionGranted = 1'b0;
        bus.busyIn             = 1'b1;
        tick();
        check_state("rs_wrdata", S_WRDATA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        check_all_zero("rs");

        bus.s_readReady        = 1'b1;
        bus.s_address          = 32'h0000_0700;
        bus.transactionGranted = 1'b1;
        tick();
        bus.s_readReady = 1'b0;
        tick();
        bus.transactionGranted = 1'b0;
        check("rs_rd_addr", bus.addressDataOut, 32'h0000_0700);
        tick();
        bus.dataValidIn      = 1'b1;
        bus.endTransactionIn = 1'b1;
        bus.addressDataIn    = 32'h55AA_55AA;
        tick();
        clear_inputs();
        check("rs_rd_send", 32'(bus.s_endTransaction), 1);
        check("rs_rd_sdv", 32'(bus.s_dataValid), 1);
        check("rs_rd_data", bus.s_readData, 32'h55AA_55AA);
        check("rs_rd_err", 32'(bus.s_error), 0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
